pwm_duty_sequencer: RTL

Controller for the LED PWM datapath. It owns the free-running period counter and the duty compare, and accepts duty-change requests over a valid/ready handshake. Each request either jumps to the new duty or ramps to it one duty LSB at a time, with a fixed number of PWM periods per step. All duty changes take effect only at period boundaries, so the output never produces a glitched or truncated pulse. It sits between the switch/host request logic and the LED pin.

---
 rtl/pwm_duty_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - PWM period counter, duty compare and jump/ramp duty sequencer
module pwm_duty_sequencer #(
  parameter int CBITS        = 14,
  parameter int DBITS        = 4,
  parameter int STEP_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DBITS-1:0] req_duty,
  input  logic             req_fast,
  output logic [DBITS-1:0] duty_cur,
  output logic             busy,
  output logic             period_end,
  output logic             pulse
);
  localparam int SBITS = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SBITS-1:0] STEP_LAST = SBITS'(STEP_PERIODS - 1);

  typedef enum logic [1:0] {IDLE, RAMP, JUMP} state_t;

  state_t           state;
  logic [CBITS-1:0] cnt;
  logic [CBITS-1:0] threshold;
  logic [DBITS-1:0] target;
  logic [DBITS-1:0] duty_next;
  logic [SBITS-1:0] step_cnt;

  assign threshold  = {duty_cur, {(CBITS-DBITS){1'b0}}};
  assign period_end = &cnt;
  assign req_ready  = (state == IDLE);
  assign busy       = !req_ready;
  // Only used in RAMP, where target differs from duty_cur, so this never wraps.
  assign duty_next  = (target > duty_cur) ? duty_cur + DBITS'(1) : duty_cur - DBITS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      cnt   <= cnt + CBITS'(1);
      pulse <= (cnt < threshold);
    end
  end

  // Duty only changes on a period_end edge, so the compare never sees a mid-period threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty_cur <= '0;
      target   <= '0;
      step_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            target   <= req_duty;
            step_cnt <= '0;
            if (req_duty != duty_cur) begin
              state <= req_fast ? JUMP : RAMP;
            end
          end
        end
        JUMP: begin
          if (period_end) begin
            duty_cur <= target;
            state    <= IDLE;
          end
        end
        RAMP: begin
          if (period_end) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              duty_cur <= duty_next;
              if (duty_next == target) begin
                state <= IDLE;
              end
            end else begin
              step_cnt <= step_cnt + SBITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
